router_op_lut_table_arb: RTL and testbench

Two-requester arbiter and sequencer for one output-port-lookup table (LPM, ARP or destination-IP filter) rd/wr port. It sits between the table and its two clients, the register-path front end (requester 0) and the table maintenance/aging engine (requester 1). It serializes their accesses with round-robin fairness and drives the table's req/ack handshake. A stalled table is bounded by a timeout that reports an error instead of hanging the register bus.

---
 rtl/router_op_lut_table_arb.sv | 135 +++++++++++++
 tb/tb_router_op_lut_table_arb.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_op_lut_table_arb.sv
// ---------------------------------------------------------------------------
// router_op_lut_table_arb
// Round-robin arbiter and sequencer for one output-port-lookup table rd/wr
// port shared by two requesters (0: register front end, 1: aging engine).
// One access at a time; a stalled table is bounded by a timeout that
// completes the access with an error and counts it.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   req_rd/req_wr[i]     level requests, held until req_ack[i]
//   req_addr/req_wr_data per-requester index / write entry (sampled in IDLE)
//   req_ack/req_err[i]   one-cycle completion pulse, error flag with it
//   req_rd_data          shared read data, valid with req_ack
//   tbl_*_req/addr/data  table request, level until its ack
//   tbl_rd_data/acks     table response, one-cycle ack pulses
//   timeout_cnt          saturating count of timed-out accesses
// ---------------------------------------------------------------------------
module router_op_lut_table_arb #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [1:0]                      req_rd,
  input  logic [1:0]                      req_wr,
  input  logic [1:0][ADDR_WIDTH-1:0]      req_addr,
  input  logic [1:0][DATA_WIDTH-1:0]      req_wr_data,
  output logic [1:0]                      req_ack,
  output logic [1:0]                      req_err,
  output logic [DATA_WIDTH-1:0]           req_rd_data,
  output logic                            tbl_rd_req,
  output logic                            tbl_wr_req,
  output logic [ADDR_WIDTH-1:0]           tbl_rd_addr,
  output logic [ADDR_WIDTH-1:0]           tbl_wr_addr,
  output logic [DATA_WIDTH-1:0]           tbl_wr_data,
  input  logic [DATA_WIDTH-1:0]           tbl_rd_data,
  input  logic                            tbl_rd_ack,
  input  logic                            tbl_wr_ack,
  output logic [15:0]                     timeout_cnt
);

  localparam int unsigned TMR_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic             r_is_wr;
  logic [TMR_W-1:0] r_timer;

  logic [1:0] w_pend;
  logic       w_grant;
  logic       w_ack_ok;
  logic       w_expired;

  // Tie goes to the requester not served last; otherwise the lone pending one.
  assign w_pend    = req_rd | req_wr;
  assign w_grant   = (&w_pend) ? ~r_last_grant : w_pend[1];
  assign w_ack_ok  = r_is_wr ? tbl_wr_ack : tbl_rd_ack;
  // r_timer counts cycles the table request has been high (1 in ISSUE).
  assign w_expired = (r_timer == TMR_W'(TIMEOUT));

  // Access sequencer with registered table and requester outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_is_wr      <= 1'b0;
      r_timer      <= '0;
      req_ack      <= '0;
      req_err      <= '0;
      req_rd_data  <= '0;
      tbl_rd_req   <= 1'b0;
      tbl_wr_req   <= 1'b0;
      tbl_rd_addr  <= '0;
      tbl_wr_addr  <= '0;
      tbl_wr_data  <= '0;
      timeout_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pend) begin
            // Write wins when both ops are set; the read stays pending.
            r_grant     <= w_grant;
            r_is_wr     <= req_wr[w_grant];
            tbl_rd_addr <= req_addr[w_grant];
            tbl_wr_addr <= req_addr[w_grant];
            tbl_wr_data <= req_wr_data[w_grant];
            tbl_rd_req  <= ~req_wr[w_grant];
            tbl_wr_req  <= req_wr[w_grant];
            r_timer     <= TMR_W'(1);
            r_state     <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // An ack on the expiry cycle still counts as success.
          if (w_ack_ok) begin
            tbl_rd_req <= 1'b0;
            tbl_wr_req <= 1'b0;
            if (!r_is_wr) begin
              req_rd_data <= tbl_rd_data;
            end
            req_ack <= r_grant ? 2'b10 : 2'b01;
            req_err <= 2'b00;
            r_state <= DONE;
          end else if (w_expired) begin
            tbl_rd_req  <= 1'b0;
            tbl_wr_req  <= 1'b0;
            req_rd_data <= '0;
            req_ack     <= r_grant ? 2'b10 : 2'b01;
            req_err     <= r_grant ? 2'b10 : 2'b01;
            if (timeout_cnt != 16'hFFFF) begin
              timeout_cnt <= 16'(timeout_cnt + 16'd1);
            end
            r_state <= DONE;
          end else begin
            r_timer <= TMR_W'(r_timer + TMR_W'(1));
            r_state <= WAIT;
          end
        end
        DONE: begin
          req_ack      <= 2'b00;
          req_err      <= 2'b00;
          r_last_grant <= r_grant;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_op_lut_table_arb.sv
// ---------------------------------------------------------------------------
// tb_router_op_lut_table_arb
// Directed bench: stimulus pushes expected table accesses and requester
// completions into queues; a table model and an ack monitor pop and compare.
// ---------------------------------------------------------------------------
module tb_router_op_lut_table_arb;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 128;
  localparam int unsigned TO = 8;

  localparam logic [DW-1:0] A5 = {16{8'hA5}};
  localparam logic [DW-1:0] DX = {4{32'h1111_0005}};
  localparam logic [DW-1:0] DY = {4{32'h2222_0006}};
  localparam logic [DW-1:0] DZ = {4{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] DW2 = {4{32'h3333_0002}};

  typedef struct {
    int          id;
    bit          err;
    bit          chk_data;
    logic [DW-1:0] data;
  } ack_t;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          rd0 = 1'b0, rd1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;

  logic [1:0]    req_ack, req_err;
  logic [DW-1:0] req_rd_data;
  logic          tbl_rd_req, tbl_wr_req;
  logic [AW-1:0] tbl_rd_addr, tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic [DW-1:0] tbl_rd_data = '0;
  logic          tbl_rd_ack = 1'b0, tbl_wr_ack = 1'b0;
  logic [15:0]   timeout_cnt;

  router_op_lut_table_arb #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_rd      ({rd1, rd0}),
    .req_wr      ({wr1, wr0}),
    .req_addr    ({a1, a0}),
    .req_wr_data ({d1, d0}),
    .req_ack     (req_ack),
    .req_err     (req_err),
    .req_rd_data (req_rd_data),
    .tbl_rd_req  (tbl_rd_req),
    .tbl_wr_req  (tbl_wr_req),
    .tbl_rd_addr (tbl_rd_addr),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .tbl_rd_data (tbl_rd_data),
    .tbl_rd_ack  (tbl_rd_ack),
    .tbl_wr_ack  (tbl_wr_ack),
    .timeout_cnt (timeout_cnt)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ack_t exp_ack[$];
  op_t  exp_op[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Table model: ack tm_delay cycles after the request rises (or never).
  logic [DW-1:0] mem [16];
  bit            mem_v [16];
  int            tm_delay = 0;
  bit            tm_noack = 1'b0;
  int            tm_cnt = 0;
  int            tm_ack_cyc = -10;
  int            tm_last_len = 0;
  bit            tm_cur_wr;
  logic [AW-1:0] tm_addr;
  op_t           tm_e;

  always @(negedge clk) begin
    tbl_rd_ack = 1'b0;
    tbl_wr_ack = 1'b0;
    if (tbl_rd_req || tbl_wr_req) begin
      chk("tbl_single_req", 128'(tbl_rd_req & tbl_wr_req), 128'(0));
      tm_cnt++;
      if (tm_cnt == 1) begin
        tm_cur_wr = tbl_wr_req;
        tm_addr   = tbl_wr_req ? tbl_wr_addr : tbl_rd_addr;
        if (exp_op.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tbl_op: unexpected table access addr %0d", tm_addr);
        end else begin
          tm_e = exp_op.pop_front();
          chk("tbl_op_wr", 128'(tm_cur_wr), 128'(tm_e.wr));
          chk("tbl_op_addr", 128'(tm_addr), 128'(tm_e.addr));
          if (tm_e.wr) chk("tbl_wr_data", tbl_wr_data, tm_e.data);
        end
      end
      if (!tm_noack && tm_cnt == tm_delay + 1) begin
        if (tm_cur_wr) begin
          tbl_wr_ack = 1'b1;
          mem[tm_addr]   = tbl_wr_data;
          mem_v[tm_addr] = 1'b1;
        end else begin
          tbl_rd_ack  = 1'b1;
          tbl_rd_data = mem_v[tm_addr] ? mem[tm_addr] : A5;
        end
        tm_ack_cyc = cyc;
      end
    end else begin
      if (tm_cnt != 0) tm_last_len = tm_cnt;
      tm_cnt = 0;
    end
  end

  // Completion monitor.
  ack_t m_e;
  always @(negedge clk) begin
    if (req_ack != 2'b00) begin
      if (exp_ack.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ack_unexpected: req_ack=%b", req_ack);
      end else begin
        m_e = exp_ack.pop_front();
        chk("ack_id", 128'(req_ack), 128'(m_e.id == 1 ? 2'b10 : 2'b01));
        chk("ack_err", 128'(req_err), 128'(m_e.err ? (m_e.id == 1 ? 2'b10 : 2'b01) : 2'b00));
        if (m_e.chk_data) chk("ack_rd_data", req_rd_data, m_e.data);
        if (!m_e.err) chk("ack_latency", 128'(cyc), 128'(tm_ack_cyc + 1));
      end
    end
  end

  task automatic set0(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd0 = rd; wr0 = wr; a0 = a; d0 = d;
  endtask

  task automatic set1(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rd1 = rd; wr1 = wr; a1 = a; d1 = d;
  endtask

  task automatic wait_ack(input int id);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req_ack[id] && n < 200);
    if (!req_ack[id]) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: requester %0d got no req_ack within 200 cycles", id);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack_err", 128'({req_ack, req_err}), 128'(0));
    chk("reset_rd_data", req_rd_data, 128'(0));
    chk("reset_tbl_ctl", 128'({tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr}), 128'(0));
    chk("reset_tcnt", 128'(timeout_cnt), 128'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Tie write(req0)/read(req1) twice each: grants alternate 0,1,0,1.
    tm_delay = 1;
    exp_op.push_back('{1'b1, 4'd5, DX});
    exp_op.push_back('{1'b0, 4'd5, '0});
    exp_op.push_back('{1'b1, 4'd6, DY});
    exp_op.push_back('{1'b0, 4'd6, '0});
    exp_ack.push_back('{0, 1'b0, 1'b0, '0});
    exp_ack.push_back('{1, 1'b0, 1'b1, DX});
    exp_ack.push_back('{0, 1'b0, 1'b0, '0});
    exp_ack.push_back('{1, 1'b0, 1'b1, DY});
    fork
      begin
        set0(1'b0, 1'b1, 4'd5, DX); wait_ack(0); set0(1'b0, 1'b0, 4'd5, DX);
        @(posedge clk); #1;
        set0(1'b0, 1'b1, 4'd6, DY); wait_ack(0); set0(1'b0, 1'b0, 4'd6, DY);
      end
      begin
        set1(1'b1, 1'b0, 4'd5, '0); wait_ack(1); set1(1'b0, 1'b0, 4'd5, '0);
        @(posedge clk); #1;
        set1(1'b1, 1'b0, 4'd6, '0); wait_ack(1); set1(1'b0, 1'b0, 4'd6, '0);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Single read of address 3, table acks 2 cycles after the request.
    tm_delay = 2;
    exp_op.push_back('{1'b0, 4'd3, '0});
    exp_ack.push_back('{0, 1'b0, 1'b1, A5});
    set0(1'b1, 1'b0, 4'd3, '0); wait_ack(0); set0(1'b0, 1'b0, 4'd3, '0);
    repeat (2) @(posedge clk);
    #1;

    // Table never acks a write from requester 1.
    tm_noack = 1'b1;
    exp_op.push_back('{1'b1, 4'd15, DZ});
    exp_ack.push_back('{1, 1'b1, 1'b1, '0});
    set1(1'b0, 1'b1, 4'd15, DZ); wait_ack(1); set1(1'b0, 1'b0, 4'd15, DZ);
    @(negedge clk);
    #1;
    chk("timeout_req_len", 128'(tm_last_len), 128'(TO));
    chk("timeout_cnt_1", 128'(timeout_cnt), 128'(1));
    tm_noack = 1'b0;
    @(posedge clk);
    #1;

    // Ack on the last allowed cycle is a success.
    tm_delay = TO - 1;
    exp_op.push_back('{1'b0, 4'd15, '0});
    exp_ack.push_back('{0, 1'b0, 1'b1, A5});
    set0(1'b1, 1'b0, 4'd15, '0); wait_ack(0); set0(1'b0, 1'b0, 4'd15, '0);
    @(posedge clk);
    #1;
    chk("edge_tcnt_same", 128'(timeout_cnt), 128'(1));

    // rd and wr together: write first, then the read sees the new entry.
    tm_delay = 1;
    exp_op.push_back('{1'b1, 4'd2, DW2});
    exp_op.push_back('{1'b0, 4'd2, '0});
    exp_ack.push_back('{0, 1'b0, 1'b0, '0});
    exp_ack.push_back('{0, 1'b0, 1'b1, DW2});
    set0(1'b1, 1'b1, 4'd2, DW2); wait_ack(0);
    set0(1'b1, 1'b0, 4'd2, DW2); wait_ack(0);
    set0(1'b0, 1'b0, 4'd2, DW2);
    repeat (2) @(posedge clk);
    #1;

    // Reset while waiting on the table: outputs clear at once, no ack.
    tm_noack = 1'b1;
    exp_op.push_back('{1'b0, 4'd4, '0});
    set1(1'b1, 1'b0, 4'd4, '0);
    n = 0;
    while (!tbl_rd_req && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rst_pre_tbl_rd_req", 128'(tbl_rd_req), 128'(1));
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_tbl_ctl", 128'({tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr}), 128'(0));
    chk("rst_ack_err", 128'({req_ack, req_err}), 128'(0));
    chk("rst_rd_data", req_rd_data, 128'(0));
    chk("rst_wr_data", tbl_wr_data, 128'(0));
    chk("rst_tcnt", 128'(timeout_cnt), 128'(0));
    set1(1'b0, 1'b0, 4'd4, '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    tm_noack = 1'b0;
    tm_delay = 0;

    // First tie after reset goes to requester 0.
    exp_op.push_back('{1'b0, 4'd7, '0});
    exp_op.push_back('{1'b0, 4'd8, '0});
    exp_ack.push_back('{0, 1'b0, 1'b1, A5});
    exp_ack.push_back('{1, 1'b0, 1'b1, A5});
    fork
      begin set0(1'b1, 1'b0, 4'd7, '0); wait_ack(0); set0(1'b0, 1'b0, 4'd7, '0); end
      begin set1(1'b1, 1'b0, 4'd8, '0); wait_ack(1); set1(1'b0, 1'b0, 4'd8, '0); end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("exp_ack_drained", 128'(exp_ack.size()), 128'(0));
    chk("exp_op_drained", 128'(exp_op.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
